// File: rtl/hfswr_rx_pkg.sv
// Shared types and constants for the receive ping-pong bank scheduler.
// No logic; the FSM states and BRAM write-port shape live here.
package hfswr_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        SKIP    = 2'd3
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] WE_ALL         = 4'hF;
    localparam int         NUM_BANKS      = 2;

    typedef struct packed {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
    } bram_wr_t;

endpackage

// File: rtl/rx_bank_sched_if.sv
// Sample stream, reader release, BRAM port-A and status bundle of the bank scheduler.
// master drives samples/sync/release; slave is the scheduler.
interface rx_bank_sched_if #(
    parameter int DATA_W = 32
);
    import hfswr_rx_pkg::*;

    logic                 sinc;
    logic                 valid;
    logic [DATA_W-1:0]    datos;
    logic [NUM_BANKS-1:0] rd_done;
    logic [31:0]          addr;
    logic [DATA_W-1:0]    din;
    logic                 en_a;
    logic [3:0]           we;
    logic [NUM_BANKS-1:0] rdy;
    logic [31:0]          size_data;
    logic                 last_bank;
    logic [15:0]          overrun_cnt;

    modport master (
        output sinc, valid, datos, rd_done,
        input  addr, din, en_a, we, rdy, size_data, last_bank, overrun_cnt
    );

    modport slave (
        input  sinc, valid, datos, rd_done,
        output addr, din, en_a, we, rdy, size_data, last_bank, overrun_cnt
    );

endinterface

// File: rtl/rx_edge_det.sv
// One-register rising-edge detector; rise is combinational from the live input.
// Zero-cycle latency on rise, no backpressure.
module rx_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/rx_bank_sched.sv
// Ping-pong scheduler writing receiver samples into a two-bank BRAM, one sweep per bank.
// Write port is 1 cycle after valid; no backpressure: samples with no open bank are dropped.
module rx_bank_sched
    import hfswr_rx_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int BASE1  = DEPTH * 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rx_bank_sched_if.slave bus
);

    localparam int             CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t               state, state_nxt;
    logic                 cur_bank, cur_bank_nxt;
    logic [CNT_W-1:0]     count, count_nxt, final_cnt;
    logic [NUM_BANKS-1:0] rdy, rdy_nxt, busy_mask;
    logic [31:0]          size_q, size_nxt;
    logic                 last_q, last_nxt;
    logic [15:0]          ovr, ovr_nxt;
    logic                 sinc_rise, wr_fire, busy, cand;
    bram_wr_t             wr;
    logic [DATA_W-1:0]    din_q;

    rx_edge_det u_sinc_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.sinc),
        .rise (sinc_rise)
    );

    assign wr_fire   = bus.valid && (state == CAPTURE) && (count < DEPTH_C);
    assign final_cnt = count + CNT_W'(wr_fire);
    assign busy      = (state == CAPTURE) || (state == HOLD);
    // The open bank is protected from a stray release by the reader.
    assign busy_mask = busy ? (NUM_BANKS'(1) << cur_bank) : '0;

    always_comb begin
        state_nxt    = state;
        cur_bank_nxt = cur_bank;
        count_nxt    = final_cnt;
        rdy_nxt      = rdy & ~(bus.rd_done & ~busy_mask);
        size_nxt     = size_q;
        last_nxt     = last_q;
        ovr_nxt      = ovr;
        cand         = cur_bank;

        if (wr_fire && (final_cnt == DEPTH_C)) begin
            state_nxt = HOLD;
        end

        if (sinc_rise) begin
            if (busy) begin
                if (final_cnt != '0) begin
                    rdy_nxt[cur_bank] = 1'b1;
                    size_nxt          = 32'(final_cnt);
                    last_nxt          = cur_bank;
                    cand              = ~cur_bank;
                end
            end else begin
                cand = rdy[0];
            end

            // Candidate is judged on the flags as registered, not this cycle's release.
            if (!rdy[cand]) begin
                state_nxt    = CAPTURE;
                cur_bank_nxt = cand;
                count_nxt    = '0;
            end else begin
                state_nxt = SKIP;
                if (ovr != 16'hFFFF) begin
                    ovr_nxt = ovr + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_bank <= 1'b0;
            count    <= '0;
            rdy      <= '0;
            size_q   <= '0;
            last_q   <= 1'b0;
            ovr      <= '0;
        end else begin
            state    <= state_nxt;
            cur_bank <= cur_bank_nxt;
            count    <= count_nxt;
            rdy      <= rdy_nxt;
            size_q   <= size_nxt;
            last_q   <= last_nxt;
            ovr      <= ovr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr    <= '0;
            din_q <= '0;
        end else begin
            wr.en <= wr_fire;
            wr.we <= wr_fire ? WE_ALL : 4'h0;
            if (wr_fire) begin
                wr.addr <= (cur_bank ? 32'(BASE1) : 32'd0)
                         + (32'(count) * 32'(BYTES_PER_WORD));
                din_q   <= bus.datos;
            end
        end
    end

    assign bus.addr        = wr.addr;
    assign bus.din         = din_q;
    assign bus.en_a        = wr.en;
    assign bus.we          = wr.we;
    assign bus.rdy         = rdy;
    assign bus.size_data   = size_q;
    assign bus.last_bank   = last_q;
    assign bus.overrun_cnt = ovr;

endmodule
